// File: rtl/decode_stage.sv
// decode_stage: registered RV32I/RV64I instruction-decode stage.
// Combinational decode of in_inst feeds a 2-entry FIFO: head is the output register, tail is the skid register.
// Optional M-extension acceptance is compiled in with the DECODE_RV_M_EN macro.
module decode_stage #(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = (XLEN == 64) ? 6 : 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [31:0]        in_inst,
    input  logic [XLEN-1:0]    in_pc,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [XLEN-1:0]    out_pc,
    output logic [6:0]         out_opcode,
    output logic [4:0]         out_rd,
    output logic [4:0]         out_rs1,
    output logic [4:0]         out_rs2,
    output logic [2:0]         out_funct3,
    output logic [6:0]         out_funct7,
    output logic [XLEN-1:0]    out_imm,
    output logic [SHAMT_W-1:0] out_shamt,
    output logic [2:0]         out_type,
    output logic               out_uses_rs1,
    output logic               out_uses_rs2,
    output logic               out_writes_rd,
    output logic               out_illegal,
    output logic               out_is_muldiv
);

    localparam logic [2:0] TYPE_R = 3'd0;
    localparam logic [2:0] TYPE_I = 3'd1;
    localparam logic [2:0] TYPE_S = 3'd2;
    localparam logic [2:0] TYPE_B = 3'd3;
    localparam logic [2:0] TYPE_U = 3'd4;
    localparam logic [2:0] TYPE_J = 3'd5;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    typedef struct packed {
        logic [XLEN-1:0]    pc;
        logic [6:0]         opcode;
        logic [4:0]         rd;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [2:0]         funct3;
        logic [6:0]         funct7;
        logic [XLEN-1:0]    imm;
        logic [SHAMT_W-1:0] shamt;
        logic [2:0]         typ;
        logic               uses_rs1;
        logic               uses_rs2;
        logic               writes_rd;
        logic               illegal;
        logic               is_muldiv;
    } entry_t;

    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

    state_t             r_state;
    state_t             w_next;
    entry_t             r_head_p1;
    entry_t             r_tail_p1;
    entry_t             w_dec_p0;
    logic               w_in_x;
    logic               w_out_x;
    logic               w_ld_head;
    logic               w_ld_tail;
    logic               w_shift;
    logic signed [31:0] w_imm32;
    logic               w_known;
    logic               w_ill_f;
    logic               w_muldiv;
    logic               w_rd_class;

    // Combinational decode of the incoming instruction word
    always_comb begin
        w_dec_p0 = '0;
        w_imm32  = '0;
        w_known  = 1'b1;
        w_ill_f  = 1'b0;
        w_muldiv = 1'b0;
        w_dec_p0.pc     = in_pc;
        w_dec_p0.opcode = in_inst[6:0];
        w_dec_p0.rs1    = in_inst[19:15];
        w_dec_p0.rs2    = in_inst[24:20];
        w_dec_p0.funct3 = in_inst[14:12];
        w_dec_p0.funct7 = in_inst[31:25];
        w_dec_p0.shamt  = in_inst[20 +: SHAMT_W];
        w_dec_p0.typ    = TYPE_I;
        case (in_inst[6:0])
            OPC_OP: begin
                w_dec_p0.typ = TYPE_R;
                if (in_inst[31:25] == 7'h20) begin
                    w_ill_f = !(in_inst[14:12] == 3'b000 || in_inst[14:12] == 3'b101);
                end else if (in_inst[31:25] == 7'h01) begin
`ifdef DECODE_RV_M_EN
                    w_muldiv = 1'b1;
`else
                    w_ill_f = 1'b1;
`endif
                end else begin
                    w_ill_f = (in_inst[31:25] != 7'h00);
                end
            end
            OPC_OP_IMM: begin
                if (in_inst[13:12] == 2'b01) begin
                    if (XLEN == 64) begin
                        w_ill_f = !(in_inst[31:26] == 6'b000000 ||
                                    (in_inst[14] && in_inst[31:26] == 6'b010000));
                    end else begin
                        w_ill_f = !(in_inst[31:25] == 7'b0000000 ||
                                    (in_inst[14] && in_inst[31:25] == 7'b0100000));
                    end
                end
            end
            OPC_JALR:     w_ill_f = (in_inst[14:12] != 3'b000);
            OPC_BRANCH: begin
                w_dec_p0.typ = TYPE_B;
                w_ill_f = (in_inst[14:13] == 2'b01);
            end
            OPC_STORE:    w_dec_p0.typ = TYPE_S;
            OPC_LUI, OPC_AUIPC: w_dec_p0.typ = TYPE_U;
            OPC_JAL:      w_dec_p0.typ = TYPE_J;
            OPC_LOAD, OPC_MISC_MEM, OPC_SYSTEM: w_dec_p0.typ = TYPE_I;
            default:      w_known = 1'b0;
        endcase
        case (w_dec_p0.typ)
            TYPE_I:  w_imm32 = $signed({{20{in_inst[31]}}, in_inst[31:20]});
            TYPE_S:  w_imm32 = $signed({{20{in_inst[31]}}, in_inst[31:25], in_inst[11:7]});
            TYPE_B:  w_imm32 = $signed({{19{in_inst[31]}}, in_inst[31], in_inst[7],
                                        in_inst[30:25], in_inst[11:8], 1'b0});
            TYPE_U:  w_imm32 = $signed({in_inst[31:12], 12'b0});
            TYPE_J:  w_imm32 = $signed({{11{in_inst[31]}}, in_inst[31], in_inst[19:12],
                                        in_inst[20], in_inst[30:21], 1'b0});
            default: w_imm32 = '0;
        endcase
        w_dec_p0.imm       = XLEN'(w_imm32);
        w_dec_p0.illegal   = (in_inst[1:0] != 2'b11) || !w_known || w_ill_f;
        w_dec_p0.is_muldiv = w_muldiv;
        w_dec_p0.uses_rs1  = (w_dec_p0.typ == TYPE_R) || (w_dec_p0.typ == TYPE_I) ||
                             (w_dec_p0.typ == TYPE_S) || (w_dec_p0.typ == TYPE_B);
        w_dec_p0.uses_rs2  = (w_dec_p0.typ == TYPE_R) || (w_dec_p0.typ == TYPE_S) ||
                             (w_dec_p0.typ == TYPE_B);
        w_rd_class         = (w_dec_p0.typ == TYPE_R) || (w_dec_p0.typ == TYPE_I) ||
                             (w_dec_p0.typ == TYPE_U) || (w_dec_p0.typ == TYPE_J);
        w_dec_p0.writes_rd = w_rd_class && !w_dec_p0.illegal && (in_inst[11:7] != 5'd0) &&
                             (in_inst[6:0] != OPC_SYSTEM) && (in_inst[6:0] != OPC_MISC_MEM);
        w_dec_p0.rd        = w_dec_p0.writes_rd ? in_inst[11:7] : 5'd0;
    end

    assign in_ready  = (r_state != TWO);
    assign out_valid = (r_state != EMPTY);
    assign w_in_x    = in_valid && in_ready;
    assign w_out_x   = out_valid && out_ready;

    // Occupancy next-state and FIFO load/shift enables; flush overrides everything
    always_comb begin
        w_next    = r_state;
        w_ld_head = 1'b0;
        w_ld_tail = 1'b0;
        w_shift   = 1'b0;
        if (flush) begin
            w_next = EMPTY;
        end else begin
            case (r_state)
                EMPTY: if (w_in_x) begin
                    w_next    = ONE;
                    w_ld_head = 1'b1;
                end
                ONE: begin
                    if (w_in_x && w_out_x) begin
                        w_ld_head = 1'b1;
                    end else if (w_in_x) begin
                        w_next    = TWO;
                        w_ld_tail = 1'b1;
                    end else if (w_out_x) begin
                        w_next = EMPTY;
                    end
                end
                TWO: if (w_out_x) begin
                    w_next  = ONE;
                    w_shift = 1'b1;
                end
                default: w_next = EMPTY;
            endcase
        end
    end

    // Occupancy state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_next;
    end

    // Stage p0 -> p1: head/tail entry storage, cleared to the idle pattern on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_head_p1     <= '0;
            r_head_p1.typ <= TYPE_I;
            r_tail_p1     <= '0;
            r_tail_p1.typ <= TYPE_I;
        end else begin
            if (w_ld_head)    r_head_p1 <= w_dec_p0;
            else if (w_shift) r_head_p1 <= r_tail_p1;
            if (w_ld_tail)    r_tail_p1 <= w_dec_p0;
        end
    end

    assign out_pc        = r_head_p1.pc;
    assign out_opcode    = r_head_p1.opcode;
    assign out_rd        = r_head_p1.rd;
    assign out_rs1       = r_head_p1.rs1;
    assign out_rs2       = r_head_p1.rs2;
    assign out_funct3    = r_head_p1.funct3;
    assign out_funct7    = r_head_p1.funct7;
    assign out_imm       = r_head_p1.imm;
    assign out_shamt     = r_head_p1.shamt;
    assign out_type      = r_head_p1.typ;
    assign out_uses_rs1  = r_head_p1.uses_rs1;
    assign out_uses_rs2  = r_head_p1.uses_rs2;
    assign out_writes_rd = r_head_p1.writes_rd;
    assign out_illegal   = r_head_p1.illegal;
    assign out_is_muldiv = r_head_p1.is_muldiv;

endmodule
